inert_seq: RTL and testbench
============================

Name: inert_seq

Overview:
Command sequencer directly upstream of the 16-bit SPI master. It drives the master's wrt/cmd handshake and consumes its done/rd_data.
- After reset: waits out the sensor power-up time, then writes three configuration registers.
- After configuration: on each data-ready interrupt, reads the low and high bytes of the yaw-rate register, assembles a 16-bit sample and pulses vld.

Parameters:
- INIT_WAIT_BITS, 16, width of the power-up wait counter; wait is 2^INIT_WAIT_BITS clocks.
- CFG0, 16'h0D02, first configuration write command.
- CFG1, 16'h1062, second configuration write command.
- CFG2, 16'h1460, third configuration write command.
- RD_LO, 16'hA600, read command for the yaw-rate low byte.
- RD_HI, 16'hA700, read command for the yaw-rate high byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- INT  in  1  sensor data-ready, asynchronous level, active-high.
- done  in  1  SPI master transaction complete (level; cleared by master on the next wrt).
- rd_data  in  16  SPI master received word; sensor byte is in [7:0].
- wrt  out  1  start-transaction pulse to SPI master.
- cmd  out  16  command word to SPI master.
- yaw_rt  out  16  assembled sample {hi,lo}, signed.
- vld  out  1  one-clock pulse when yaw_rt updates.

Behaviour:
- One clock domain; all state flops reset asynchronously on rst_n low.
- Reset values: wrt=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0, state=PWR_WAIT, idx=0, wait counter=0.
- INT passes through a two-flop synchronizer (reset 0). Only the synchronized INT_s is used.
- Completion event = rising edge of done: done=1 and done_q=0, where done_q is done registered once (reset 1). Level-high done alone never completes a transaction.
- Command index idx, 3 bits, selects cmd: 0→CFG0, 1→CFG1, 2→CFG2, 3→RD_LO, 4→RD_HI.
- PWR_WAIT:
  - Counter increments every clock.
  - On the clock it is all ones: go to ISSUE with idx=0.
- ISSUE:
  - wrt=1 for exactly one clock. cmd=table[idx] is valid on that clock and held stable until the next ISSUE.
  - Next state: WAIT_DONE.
- WAIT_DONE, on completion event:
  - idx 0,1: idx+1 → ISSUE.
  - idx 2: idx=3 → IDLE.
  - idx 3: lo_byte<=rd_data[7:0], idx=4 → ISSUE.
  - idx 4: yaw_rt<={rd_data[7:0],lo_byte}, vld=1 for the following clock, idx=3 → IDLE.
  - No event: stay.
- IDLE:
  - INT_s=1: go to ISSUE (idx=3). INT_s=0: stay.
  - INT is level-sensitive: if INT_s is still high on return to IDLE, the next read starts immediately.
- INT asserting outside IDLE (during config or a read) is not queued separately; only its level is sampled on return to IDLE.
- Latency: INT edge → wrt of RD_LO = 2 sync clocks + 1 IDLE clock + ISSUE; vld rises 1 clock after the RD_HI completion event.
- wrt never reasserts before a completion event for the previous transaction.
- Reset mid-transaction: immediate return to PWR_WAIT; full power-up wait and configuration repeat; yaw_rt cleared.
- idx values 5–7 are unreachable; if decoded, go to PWR_WAIT with cmd=16'h0000.

Optional Feature:
- Macro: INERT_SEQ_AVG_EN.
- Defined:
  - A 4-entry history of signed samples (reset 0) and an 18-bit signed running sum are maintained.
  - Each new sample: sum <= sum + new - oldest; new sample replaces oldest.
  - yaw_rt = sum[17:2], arithmetic divide by 4 truncating toward -inf; vld timing unchanged.
  - Reset clears the history and sum.
- Undefined: yaw_rt is the raw sample; no history logic is synthesized.

Test Plan:
1. INIT_WAIT_BITS=4, SPI model returns done 40 clocks after each wrt → wrt pulses in order with cmd 16'h0D02, 16'h1062, 16'h1460. First wrt occurs 17 clocks after rst_n rises. Each wrt is exactly 1 clock wide. No fourth wrt while INT=0.
2. After config, INT high 5 clocks; model rd_data=16'hxx34 for RD_LO and 16'hxx12 for RD_HI → wrt with cmd 16'hA600 then 16'hA700; yaw_rt=16'h1234; vld high exactly 1 clock.
3. INT held high continuously, hi/lo = 0xFF/0x9C then 0x00/0x05 → two back-to-back read pairs; yaw_rt 16'hFF9C then 16'h0005; two vld pulses.
4. done held high from before wrt (stale level) → no premature advance; the sequencer waits for done to fall and rise again.
5. rst_n pulsed low during the RD_HI wait → wrt=0, yaw_rt=0, vld=0 immediately; after release, power-up wait and CFG0–CFG2 repeat.
6. INERT_SEQ_AVG_EN defined, samples 16'd100, 16'd200, 16'd300, 16'd400, 16'hFFFC → yaw_rt 25, 75, 150, 250, 224.

Source files
------------

// File: rtl/inert_seq.sv
// Sensor command sequencer: power-up wait, three config writes, then a yaw-rate read pair per data-ready interrupt.
// Optional 4-sample moving average on yaw_rt when INERT_SEQ_AVG_EN is defined.
module inert_seq #(
    parameter int          INIT_WAIT_BITS = 16,
    parameter logic [15:0] CFG0           = 16'h0D02,
    parameter logic [15:0] CFG1           = 16'h1062,
    parameter logic [15:0] CFG2           = 16'h1460,
    parameter logic [15:0] RD_LO          = 16'hA600,
    parameter logic [15:0] RD_HI          = 16'hA700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    typedef enum logic [1:0] {PWR_WAIT, ISSUE, WAIT_DONE, IDLE} state_t;

    state_t                    state;
    logic [2:0]                idx;
    logic [INIT_WAIT_BITS-1:0] wait_cnt;
    logic [7:0]                lo_byte;
    logic                      int_s1, int_s;
    logic                      done_q;
    logic                      done_evt;
    logic [15:0]               sample;
    logic [15:0]               yaw_nxt;
    logic                      new_sample;
    logic                      unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    function automatic logic [15:0] cmd_lookup(input logic [2:0] i);
        case (i)
            3'd0:    cmd_lookup = CFG0;
            3'd1:    cmd_lookup = CFG1;
            3'd2:    cmd_lookup = CFG2;
            3'd3:    cmd_lookup = RD_LO;
            3'd4:    cmd_lookup = RD_HI;
            default: cmd_lookup = 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b0;
            int_s  <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s  <= int_s1;
        end
    end

    // done_q resets high so a done level already present at reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b1;
        else        done_q <= done;
    end

    assign done_evt   = done & ~done_q;
    assign sample     = {rd_data[7:0], lo_byte};
    assign new_sample = (state == WAIT_DONE) && done_evt && (idx == 3'd4);

`ifdef INERT_SEQ_AVG_EN
    logic [3:0][15:0]   hist;
    logic [1:0]         hptr;
    logic signed [17:0] sum, sum_nxt;

    assign sum_nxt = sum + $signed({{2{sample[15]}}, sample})
                         - $signed({{2{hist[hptr][15]}}, hist[hptr]});
    // Taking the upper bits of the sum divides by 4 rounding toward -inf.
    assign yaw_nxt = sum_nxt[17:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            hptr <= 2'd0;
            sum  <= '0;
        end else if (new_sample) begin
            hist[hptr] <= sample;
            hptr       <= hptr + 2'd1;
            sum        <= sum_nxt;
        end
    end
`else
    assign yaw_nxt = sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PWR_WAIT;
            idx      <= 3'd0;
            wait_cnt <= '0;
            lo_byte  <= 8'h00;
            wrt      <= 1'b0;
            cmd      <= 16'h0000;
            yaw_rt   <= 16'h0000;
            vld      <= 1'b0;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (&wait_cnt) begin
                        state <= ISSUE;
                        idx   <= 3'd0;
                    end
                end
                ISSUE: begin
                    if (idx > 3'd4) begin
                        state    <= PWR_WAIT;
                        cmd      <= 16'h0000;
                        idx      <= 3'd0;
                        wait_cnt <= '0;
                    end else begin
                        wrt   <= 1'b1;
                        cmd   <= cmd_lookup(idx);
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (idx > 3'd4) begin
                        state    <= PWR_WAIT;
                        cmd      <= 16'h0000;
                        idx      <= 3'd0;
                        wait_cnt <= '0;
                    end else if (done_evt) begin
                        case (idx)
                            3'd0, 3'd1: begin
                                idx   <= idx + 3'd1;
                                state <= ISSUE;
                            end
                            3'd2: begin
                                idx   <= 3'd3;
                                state <= IDLE;
                            end
                            3'd3: begin
                                lo_byte <= rd_data[7:0];
                                idx     <= 3'd4;
                                state   <= ISSUE;
                            end
                            default: begin
                                yaw_rt <= yaw_nxt;
                                vld    <= 1'b1;
                                idx    <= 3'd3;
                                state  <= IDLE;
                            end
                        endcase
                    end
                end
                IDLE: begin
                    // Level-sensitive: a still-high INT starts the next read pair at once.
                    if (int_s) begin
                        idx   <= 3'd3;
                        state <= ISSUE;
                    end
                end
                default: begin
                    state    <= PWR_WAIT;
                    cmd      <= 16'h0000;
                    idx      <= 3'd0;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inert_seq.sv
// Directed bench for inert_seq: SPI master model with 40-clock turnaround, vector table of read pairs,
// stale-done and mid-read reset sequences. Expected yaw values follow INERT_SEQ_AVG_EN.
module tb_inert_seq;
    localparam logic [15:0] CFG0  = 16'h0D02;
    localparam logic [15:0] CFG1  = 16'h1062;
    localparam logic [15:0] CFG2  = 16'h1460;
    localparam logic [15:0] RD_LO = 16'hA600;
    localparam logic [15:0] RD_HI = 16'hA700;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        INT = 1'b0;
    logic        auto_en = 1'b1;
    logic        a_done = 1'b0, m_done = 1'b0;
    logic [15:0] a_rd = 16'h0000, m_rd = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt, vld;
    logic [15:0] cmd, yaw_rt;

    assign done    = auto_en ? a_done : m_done;
    assign rd_data = auto_en ? a_rd : m_rd;

    always #5 clk = ~clk;

    inert_seq #(.INIT_WAIT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld)
    );

    int          total = 0, bad = 0;
    int          spi_cnt = 0;
    logic [15:0] pend = 16'h0000;
    logic [7:0]  rq[$];
    logic [15:0] wlog[$];
    int          vld_cnt = 0, wrt_wide = 0, vld_wide = 0;
    logic        wrt_prev = 1'b0, vld_prev = 1'b0;

    // SPI master model and output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            spi_cnt  = 0;
            wrt_prev = 1'b0;
            vld_prev = 1'b0;
        end else begin
            if (wrt) begin
                wlog.push_back(cmd);
                if (wrt_prev) wrt_wide++;
            end
            if (vld) begin
                vld_cnt++;
                if (vld_prev) vld_wide++;
            end
            wrt_prev = wrt;
            vld_prev = vld;
            if (auto_en) begin
                if (wrt) begin
                    a_done  = 1'b0;
                    spi_cnt = 40;
                    pend    = 16'h0000;
                    if ((cmd == RD_LO || cmd == RD_HI) && rq.size() > 0)
                        pend = {8'hA5, rq.pop_front()};
                end else if (spi_cnt > 0) begin
                    spi_cnt--;
                    if (spi_cnt == 0) begin
                        a_done = 1'b1;
                        a_rd   = pend;
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_wrts(input int target, input int maxc, input string nm);
        int i = 0;
        while (wlog.size() < target && i < maxc) begin
            tick(1);
            i++;
        end
        check(nm, wlog.size(), target);
    endtask

    task automatic wait_vld(input int target, input int maxc, input string nm);
        int i = 0;
        while (vld_cnt < target && i < maxc) begin
            tick(1);
            i++;
        end
        check(nm, vld_cnt, target);
    endtask

    // Release reset, check power-up timing and the three config writes.
    task automatic release_and_cfg(input string tag);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
        do begin
            tick(1);
            n++;
        end while (!wrt && n < 100);
        check({tag, "_first_wrt_clk"}, n, 17);
        wait_wrts(3, 200, {tag, "_cfg_wrts"});
        tick(100);
        check({tag, "_no_4th_wrt"}, wlog.size(), 3);
        if (wlog.size() >= 3) begin
            check({tag, "_cmd0"}, wlog[0], CFG0);
            check({tag, "_cmd1"}, wlog[1], CFG1);
            check({tag, "_cmd2"}, wlog[2], CFG2);
        end
    endtask

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          hold;
        bit          keep;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] stale_exp;

    initial begin
`ifdef INERT_SEQ_AVG_EN
        vecs.push_back('{8'h64, 8'h00, 5, 1'b0, 16'd25});
        vecs.push_back('{8'hC8, 8'h00, 5, 1'b0, 16'd75});
        vecs.push_back('{8'h2C, 8'h01, 5, 1'b0, 16'd150});
        vecs.push_back('{8'h90, 8'h01, 5, 1'b0, 16'd250});
        vecs.push_back('{8'hFC, 8'hFF, 5, 1'b0, 16'd224});
        stale_exp = 16'h164C;
`else
        vecs.push_back('{8'h34, 8'h12, 5, 1'b0, 16'h1234});
        vecs.push_back('{8'h9C, 8'hFF, 5, 1'b1, 16'hFF9C});
        vecs.push_back('{8'h05, 8'h00, 5, 1'b0, 16'h0005});
        stale_exp = 16'h5678;
`endif
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_yaw", yaw_rt, 16'h0000);
        check("rst_vld", vld, 0);

        release_and_cfg("cfg");

        // Read pairs; keep=1 leaves INT high so the next pair runs back to back.
        foreach (vecs[i]) begin
            int nv;
            rq.push_back(vecs[i].lo);
            rq.push_back(vecs[i].hi);
            nv  = vld_cnt;
            INT = 1'b1;
            tick(vecs[i].hold);
            if (!vecs[i].keep) INT = 1'b0;
            wait_vld(nv + 1, 300, $sformatf("vec%0d_vld", i));
            check($sformatf("vec%0d_yaw", i), yaw_rt, vecs[i].exp);
        end
        INT = 1'b0;
        tick(100);
        check("rd_wrt_count", wlog.size(), 3 + 2 * vecs.size());
        for (int k = 3; k < wlog.size(); k++)
            check($sformatf("rd_cmd%0d", k), wlog[k], (k % 2 == 1) ? RD_LO : RD_HI);

        // Stale done level across wrt must not count as completion.
        begin
            int w0, nv;
            m_done  = 1'b1;
            m_rd    = 16'h0000;
            auto_en = 1'b0;
            w0  = wlog.size();
            INT = 1'b1;
            tick(5);
            INT = 1'b0;
            wait_wrts(w0 + 1, 50, "stale_lo_wrt");
            tick(20);
            check("stale_no_adv", wlog.size(), w0 + 1);
            m_done = 1'b0;
            m_rd   = {8'h5A, 8'h78};
            tick(2);
            m_done = 1'b1;
            wait_wrts(w0 + 2, 10, "stale_hi_wrt");
            if (wlog.size() >= w0 + 2) check("stale_hi_cmd", wlog[w0 + 1], RD_HI);
            nv = vld_cnt;
            tick(20);
            check("stale_no_vld", vld_cnt, nv);
            m_done = 1'b0;
            m_rd   = {8'h5A, 8'h56};
            tick(2);
            m_done = 1'b1;
            wait_vld(nv + 1, 10, "stale_vld");
            check("stale_yaw", yaw_rt, stale_exp);
            auto_en = 1'b1;
        end

        // Reset while waiting on the RD_HI transaction.
        begin
            int w0;
            rq.push_back(8'h11);
            rq.push_back(8'h22);
            w0  = wlog.size();
            INT = 1'b1;
            tick(5);
            INT = 1'b0;
            wait_wrts(w0 + 2, 200, "mid_rd_wrts");
            tick(10);
            #3 rst_n = 1'b0;
            #1;
            check("mid_rst_wrt", wrt, 0);
            check("mid_rst_yaw", yaw_rt, 16'h0000);
            check("mid_rst_vld", vld, 0);
            check("mid_rst_cmd", cmd, 16'h0000);
            rq.delete();
            tick(2);
            release_and_cfg("recfg");
        end

        check("wrt_one_clk", wrt_wide, 0);
        check("vld_one_clk", vld_wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
